graph_run_scheduler: RTL

Top-level sequencer for the arbitrage graph engine. Shares the vertex-matrix and adjacency-matrix RAM ports between the host edge-update path and three compute engines: vertex-init, Bellman-Ford relax pass, and cycle detect. Runs one complete detection run per request: init, up to NODES-1 relax passes with early exit, then cycle detect. It drives the engines' start pulses and the memory-port owner select.

---
 rtl/graph_run_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/graph_run_scheduler.sv
// graph_run_scheduler: sequences one arbitrage detection run.
// A run is vertex-init, then up to NODES-1 Bellman-Ford relax passes, then cycle detect.
// The block also arbitrates the shared vertex/adjacency RAM ports between the host
// edge-update path and the compute engines.
module graph_run_scheduler #(
  parameter int NODES = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             upd_req,
  output logic             upd_gnt,
  input  logic             run_req,
  output logic             init_start,
  output logic             relax_start,
  output logic             cycle_start,
  input  logic             init_done,
  input  logic             relax_done,
  input  logic             cycle_done,
  input  logic             relax_changed,
  output logic [1:0]       mem_owner,
  output logic             busy,
  output logic             run_done,
  output logic [CNT_W-1:0] passes_used,
  output logic             early_exit,
  output logic [CNT_W-1:0] run_count
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_UPDATE     = 4'd1,
    S_INIT_GO    = 4'd2,
    S_INIT_WAIT  = 4'd3,
    S_RELAX_GO   = 4'd4,
    S_RELAX_WAIT = 4'd5,
    S_DET_GO     = 4'd6,
    S_DET_WAIT   = 4'd7,
    S_FINISH     = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NODES - 1);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_HOST  = 2'd1;
  localparam logic [1:0] OWN_RELAX = 2'd2;
  localparam logic [1:0] OWN_DET   = 2'd3;

  state_t           state_q, state_d;
  logic             guard_q;     // high on the first cycle of any WAIT state
  logic [CNT_W-1:0] pc_q;        // relax passes issued in the current run
  logic             early_q;     // current run left relaxing on no-change
  logic             run_pend_q;  // a run request arrived while it could not be taken
  logic             run_pend_d;

  logic             upd_gnt_q, init_start_q, relax_start_q, cycle_start_q;
  logic [1:0]       mem_owner_q;
  logic             busy_q, run_done_q, early_exit_q;
  logic [CNT_W-1:0] passes_used_q, run_count_q;

  logic             run_taken;

  // Next-state decode; WAIT states only look at their done input once the guard has cleared.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (upd_req)                      state_d = S_UPDATE;
        else if (run_req || run_pend_q)   state_d = S_INIT_GO;
      end
      S_UPDATE:    if (!upd_req)                  state_d = S_IDLE;
      S_INIT_GO:                                  state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (!guard_q && init_done)     state_d = S_RELAX_GO;
      S_RELAX_GO:                                 state_d = S_RELAX_WAIT;
      S_RELAX_WAIT: begin
        if (!guard_q && relax_done) begin
          if (!relax_changed || pc_q == LAST_PASS) state_d = S_DET_GO;
          else                                     state_d = S_RELAX_GO;
        end
      end
      S_DET_GO:                                   state_d = S_DET_WAIT;
      S_DET_WAIT:  if (!guard_q && cycle_done)    state_d = S_FINISH;
      S_FINISH:                                   state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  // A request is consumed directly only when IDLE launches a run in the same cycle.
  assign run_taken = (state_q == S_IDLE) && (state_d == S_INIT_GO);

  // Pending-request latch: any request not consumed immediately is remembered once.
  always_comb begin
    run_pend_d = run_pend_q;
    if (run_req && !((state_q == S_IDLE) && !upd_req)) run_pend_d = 1'b1;
    if (run_taken)                                      run_pend_d = 1'b0;
  end

  // Sequencer state, run bookkeeping and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      guard_q       <= 1'b0;
      pc_q          <= '0;
      early_q       <= 1'b0;
      run_pend_q    <= 1'b0;
      upd_gnt_q     <= 1'b0;
      init_start_q  <= 1'b0;
      relax_start_q <= 1'b0;
      cycle_start_q <= 1'b0;
      mem_owner_q   <= OWN_NONE;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      early_exit_q  <= 1'b0;
      passes_used_q <= '0;
      run_count_q   <= '0;
    end else begin
      state_q    <= state_d;
      run_pend_q <= run_pend_d;

      // Every WAIT state is entered only from its GO state, so this marks its first cycle.
      guard_q <= (state_q == S_INIT_GO) || (state_q == S_RELAX_GO) || (state_q == S_DET_GO);

      if (state_q == S_INIT_WAIT && state_d == S_RELAX_GO) pc_q <= '0;
      else if (state_q == S_RELAX_GO)                      pc_q <= pc_q + 1'b1;

      if (run_taken)
        early_q <= 1'b0;
      else if (state_q == S_RELAX_WAIT && state_d == S_DET_GO && !relax_changed)
        early_q <= 1'b1;

      upd_gnt_q     <= (state_d == S_UPDATE);
      init_start_q  <= (state_d == S_INIT_GO);
      relax_start_q <= (state_d == S_RELAX_GO);
      cycle_start_q <= (state_d == S_DET_GO);
      busy_q        <= (state_d != S_IDLE);
      run_done_q    <= (state_d == S_FINISH);

      case (state_d)
        S_UPDATE:                                          mem_owner_q <= OWN_HOST;
        S_INIT_GO, S_INIT_WAIT, S_RELAX_GO, S_RELAX_WAIT:  mem_owner_q <= OWN_RELAX;
        S_DET_GO, S_DET_WAIT:                              mem_owner_q <= OWN_DET;
        default:                                           mem_owner_q <= OWN_NONE;
      endcase

      if (state_d == S_FINISH) begin
        passes_used_q <= pc_q;
        early_exit_q  <= early_q;
        run_count_q   <= run_count_q + 1'b1;
      end
    end
  end

  assign upd_gnt     = upd_gnt_q;
  assign init_start  = init_start_q;
  assign relax_start = relax_start_q;
  assign cycle_start = cycle_start_q;
  assign mem_owner   = mem_owner_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign passes_used = passes_used_q;
  assign early_exit  = early_exit_q;
  assign run_count   = run_count_q;

endmodule
